reaction_timer: RTL and testbench
=================================

REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 The block SHALL have parameter MAX_BCD, default 16'h9999: the saturation value of the 4-digit BCD count.
REQ-002 The block SHALL have parameter TICK_MS, default 1: milliseconds per tick, for documentation only, with no RTL effect.
REQ-003 Port clk SHALL be an input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-005 Port start SHALL be an input, 1 bit: a one-cycle pulse that arms a new measurement.
REQ-006 Port time_out SHALL be an input, 1 bit: the level from the upstream delay stage; its rising edge starts timing.
REQ-007 Port tick SHALL be an input, 1 bit: a one-cycle count-enable pulse, one per millisecond.
REQ-008 Port key SHALL be an input, 1 bit: the stop key, active-high, already synchronised and debounced.
REQ-009 Port led SHALL be an output, 1 bit: high while measuring.
REQ-010 Port bcd SHALL be an output, 16 bits: four BCD digits, with the ms count in bits [3:0] as the LSD.
REQ-011 Port done SHALL be an output, 1 bit: a one-cycle pulse when a valid result is latched.
REQ-012 Port early SHALL be an output, 1 bit: a level, high after a premature key press.

Function
REQ-013 The FSM SHALL have the states IDLE, ARMED, MEASURE, HOLD and EARLY.
REQ-014 The block SHALL register time_out internally; a rising edge is time_out=1 while the registered copy is 0.
REQ-015 In IDLE, HOLD or EARLY, start=1 SHALL move the FSM to ARMED on the next edge, with bcd cleared to 0 and early cleared to 0.
REQ-016 In ARMED, key=1 SHALL move the FSM to EARLY and set early=1.
REQ-017 In ARMED, a time_out rising edge with key=0 SHALL move the FSM to MEASURE, with led=1 and bcd=0.
REQ-018 In ARMED, a key press and a time_out rising edge in the same cycle SHALL resolve to EARLY (key wins).
REQ-019 In MEASURE, each tick=1 with key=0 SHALL increment bcd by one in BCD (digit 9 wraps to 0 with carry to the next digit).
REQ-020 bcd SHALL saturate at MAX_BCD: further ticks leave it unchanged and the FSM stays in MEASURE.
REQ-021 In MEASURE, key=1 SHALL move the FSM to HOLD, set led=0, pulse done=1 for exactly one cycle and freeze bcd; a tick in that same cycle SHALL NOT be counted.
REQ-022 HOLD and EARLY SHALL ignore key, tick and time_out.
REQ-023 start=1 in ARMED or MEASURE SHALL restart: the FSM goes to ARMED, bcd=0, led=0, and done is not pulsed.
REQ-024 The registered outputs SHALL have a latency of one clk cycle from the triggering input.
REQ-025 A time_out level already high when ARMED is entered SHALL NOT start timing; a fresh rising edge is required.

Reset
REQ-026 rst_n=0 at a clk edge SHALL force IDLE with led=0, bcd=16'h0000, done=0, early=0 and the time_out register at 0.
REQ-027 Reset SHALL take priority over all inputs, including mid-MEASURE, and the count SHALL be discarded.

Configuration
REQ-028 When macro REACT_EARLY_DETECT_EN is defined, ARMED SHALL behave per REQ-016 and REQ-018.
REQ-029 When REACT_EARLY_DETECT_EN is undefined, key SHALL be ignored in ARMED, the EARLY state is not built, and early SHALL be tied to 0.

Structure
REQ-030 Package react_pkg SHALL hold the state enum type, the BCD digit width constant (4) and the digit count constant (4).
REQ-031 Sub-module bcd_counter4 SHALL implement a 4-digit BCD counter with synchronous clear, enable and saturation at MAX_BCD; reaction_timer SHALL instantiate it once.

Verification
REQ-032 Scenario: reset, start, time_out rises, 237 ticks, then key -> bcd=16'h0237, a single done pulse, led falls on the key cycle.
REQ-033 Scenario: in ARMED, key=1 before time_out -> early=1, state EARLY, bcd=0, no done pulse; with the macro undefined -> early stays 0 and timing starts on time_out.
REQ-034 Scenario: key and time_out rising in the same cycle -> EARLY (macro defined).
REQ-035 Scenario: 10050 ticks in MEASURE -> bcd holds 16'h9999; key -> done pulse, bcd=16'h9999.
REQ-036 Scenario: tick and key in the same cycle at bcd=16'h0099 -> bcd stays 16'h0099; carry check: 9 more ticks from 16'h0091 -> 16'h0100.
REQ-037 Scenario: rst_n=0 mid-MEASURE at bcd=16'h0042 -> next cycle all outputs 0, state IDLE; time_out held high then start -> no timing until time_out falls and rises.

Source files
------------

// File: rtl/react_pkg.sv
// Shared types and constants for the reaction timer: FSM state encoding and BCD geometry.
// The EARLY state only exists when REACT_EARLY_DETECT_EN is defined.
package react_pkg;

    localparam int BCD_W      = 4;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_BITS   = BCD_W * BCD_DIGITS;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        MEASURE,
`ifdef REACT_EARLY_DETECT_EN
        HOLD,
        EARLY
`else
        HOLD
`endif
    } state_t;

    function automatic logic [BCD_W-1:0] bcd_digit_inc(input logic [BCD_W-1:0] d);
        return (d == BCD_W'(9)) ? '0 : d + BCD_W'(1);
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Control/status bundle between the reaction timer and its surroundings.
// master drives the stimulus side (start, time_out, tick, key); slave is the timer.
interface reaction_timer_if;
    import react_pkg::*;

    logic                start;
    logic                time_out;
    logic                tick;
    logic                key;
    logic                led;
    logic [BCD_BITS-1:0] bcd;
    logic                done;
    logic                early;

    modport master (
        output start, time_out, tick, key,
        input  led, bcd, done, early
    );

    modport slave (
        input  start, time_out, tick, key,
        output led, bcd, done, early
    );
endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, count enable and saturation at MAX_BCD.
module bcd_counter4
    import react_pkg::*;
#(
    parameter logic [BCD_BITS-1:0] MAX_BCD = 16'h9999
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    output logic [BCD_BITS-1:0] count
);

    logic [BCD_BITS-1:0]   count_reg;
    logic [BCD_BITS-1:0]   count_next;
    logic [BCD_DIGITS-1:0] carry;

    // Saturation blocks the increment at the source of the ripple chain.
    assign carry[0] = en && (count_reg != MAX_BCD);

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            logic [BCD_W-1:0] digit;
            assign digit = count_reg[gi*BCD_W +: BCD_W];
            assign count_next[gi*BCD_W +: BCD_W] = carry[gi] ? bcd_digit_inc(digit) : digit;
            if (gi < BCD_DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] && (digit == BCD_W'(9));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: arms on start, times from the time_out rising edge until key, in BCD milliseconds.
// Define REACT_EARLY_DETECT_EN to flag key presses made while still ARMED (EARLY state).
module reaction_timer
    import react_pkg::*;
#(
    parameter logic [BCD_BITS-1:0] MAX_BCD = 16'h9999,
    parameter int                  TICK_MS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    reaction_timer_if.slave   io
);

    if (TICK_MS < 1) begin : g_bad_tick_ms
        $error("TICK_MS must be at least 1");
    end

    state_t state_reg, state_next;
    logic   to_q_reg;
    logic   led_reg, led_next;
    logic   done_reg, done_next;
    logic   cnt_clr, cnt_en;
    logic   to_rise;

    assign to_rise = io.time_out && !to_q_reg;

`ifdef REACT_EARLY_DETECT_EN
    logic early_reg, early_next;
`endif

    always_comb begin
        state_next = state_reg;
        led_next   = led_reg;
        done_next  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
`ifdef REACT_EARLY_DETECT_EN
        early_next = early_reg;
`endif
        // start restarts from any state and never produces a done pulse.
        if (io.start) begin
            state_next = ARMED;
            led_next   = 1'b0;
            cnt_clr    = 1'b1;
`ifdef REACT_EARLY_DETECT_EN
            early_next = 1'b0;
`endif
        end else begin
            case (state_reg)
                ARMED: begin
`ifdef REACT_EARLY_DETECT_EN
                    if (io.key) begin
                        state_next = EARLY;
                        early_next = 1'b1;
                    end else if (to_rise) begin
                        state_next = MEASURE;
                        led_next   = 1'b1;
                        cnt_clr    = 1'b1;
                    end
`else
                    if (to_rise) begin
                        state_next = MEASURE;
                        led_next   = 1'b1;
                        cnt_clr    = 1'b1;
                    end
`endif
                end
                MEASURE: begin
                    // The stop key wins over a coincident tick so the frozen value is exact.
                    if (io.key) begin
                        state_next = HOLD;
                        led_next   = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        cnt_en = io.tick;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            to_q_reg  <= 1'b0;
            led_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            to_q_reg  <= io.time_out;
            led_reg   <= led_next;
            done_reg  <= done_next;
        end
    end

`ifdef REACT_EARLY_DETECT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            early_reg <= 1'b0;
        end else begin
            early_reg <= early_next;
        end
    end
    assign io.early = early_reg;
`else
    assign io.early = 1'b0;
`endif

    bcd_counter4 #(
        .MAX_BCD (MAX_BCD)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (io.bcd)
    );

    assign io.led  = led_reg;
    assign io.done = done_reg;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer; expectations adapt to whether REACT_EARLY_DETECT_EN is defined.
module tb_reaction_timer;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    reaction_timer_if rt_if();

    reaction_timer #(
        .MAX_BCD (16'h9999),
        .TICK_MS (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (rt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        rt_if.tick = 1'b1;
        repeat (n) cyc();
        rt_if.tick = 1'b0;
    endtask

    task automatic do_start();
        rt_if.start = 1'b1;
        cyc();
        rt_if.start = 1'b0;
    endtask

    task automatic outs(input string tag, input logic led, input logic [15:0] bcd,
                        input logic done, input logic early);
        check({tag, ".led"},   32'(rt_if.led),   32'(led));
        check({tag, ".bcd"},   32'(rt_if.bcd),   32'(bcd));
        check({tag, ".done"},  32'(rt_if.done),  32'(done));
        check({tag, ".early"}, 32'(rt_if.early), 32'(early));
    endtask

    localparam logic EDET =
`ifdef REACT_EARLY_DETECT_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        rt_if.start = 1'b0;
        rt_if.time_out = 1'b0;
        rt_if.tick = 1'b0;
        rt_if.key = 1'b0;
        cyc();
        cyc();
        outs("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Basic measurement of 237 ms.
        do_start();
        outs("armed", 1'b0, 16'h0000, 1'b0, 1'b0);
        rt_if.time_out = 1'b1;
        cyc();
        outs("measure", 1'b1, 16'h0000, 1'b0, 1'b0);
        ticks(237);
        check("cnt237", 32'(rt_if.bcd), 32'h0237);
        rt_if.key = 1'b1;
        cyc();
        rt_if.key = 1'b0;
        outs("stop237", 1'b0, 16'h0237, 1'b1, 1'b0);
        cyc();
        check("done_once", 32'(rt_if.done), 32'h0);
        rt_if.key = 1'b1;
        rt_if.tick = 1'b1;
        rt_if.time_out = 1'b0;
        cyc();
        rt_if.time_out = 1'b1;
        cyc();
        cyc();
        rt_if.key = 1'b0;
        rt_if.tick = 1'b0;
        outs("hold_ignore", 1'b0, 16'h0237, 1'b0, 1'b0);

        // Tick coincident with key at 0099 is not counted.
        rt_if.time_out = 1'b0;
        do_start();
        check("rearm_clr", 32'(rt_if.bcd), 32'h0);
        rt_if.time_out = 1'b1;
        cyc();
        ticks(99);
        check("cnt99", 32'(rt_if.bcd), 32'h0099);
        rt_if.tick = 1'b1;
        rt_if.key = 1'b1;
        cyc();
        rt_if.tick = 1'b0;
        rt_if.key = 1'b0;
        outs("tick_key", 1'b0, 16'h0099, 1'b1, 1'b0);

        // Carry from 0091 to 0100, then restart mid-MEASURE.
        rt_if.time_out = 1'b0;
        do_start();
        rt_if.time_out = 1'b1;
        cyc();
        ticks(91);
        check("cnt91", 32'(rt_if.bcd), 32'h0091);
        ticks(9);
        check("carry100", 32'(rt_if.bcd), 32'h0100);
        do_start();
        outs("restart", 1'b0, 16'h0000, 1'b0, 1'b0);

        // Key while ARMED (time_out stays high: no fresh edge).
        rt_if.key = 1'b1;
        cyc();
        rt_if.key = 1'b0;
        outs("armed_key", 1'b0, 16'h0000, 1'b0, EDET);
        rt_if.time_out = 1'b0;
        cyc();
        rt_if.time_out = 1'b1;
        cyc();
        outs("after_key_rise", !EDET, 16'h0000, 1'b0, EDET);

        // Key and time_out rising in the same cycle.
        rt_if.time_out = 1'b0;
        do_start();
        check("early_clr", 32'(rt_if.early), 32'h0);
        rt_if.key = 1'b1;
        rt_if.time_out = 1'b1;
        cyc();
        rt_if.key = 1'b0;
        outs("key_and_rise", !EDET, 16'h0000, 1'b0, EDET);

        // Saturation at 9999.
        rt_if.time_out = 1'b0;
        do_start();
        rt_if.time_out = 1'b1;
        cyc();
        ticks(10050);
        check("sat_bcd", 32'(rt_if.bcd), 32'h9999);
        check("sat_led", 32'(rt_if.led), 32'h1);
        rt_if.key = 1'b1;
        cyc();
        rt_if.key = 1'b0;
        outs("sat_stop", 1'b0, 16'h9999, 1'b1, 1'b0);

        // Reset mid-MEASURE, then time_out already high when ARMED.
        rt_if.time_out = 1'b0;
        do_start();
        rt_if.time_out = 1'b1;
        cyc();
        ticks(42);
        check("cnt42", 32'(rt_if.bcd), 32'h0042);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        outs("mid_reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        do_start();
        ticks(5);
        outs("level_high", 1'b0, 16'h0000, 1'b0, 1'b0);
        rt_if.time_out = 1'b0;
        cyc();
        rt_if.time_out = 1'b1;
        cyc();
        check("fresh_rise", 32'(rt_if.led), 32'h1);
        ticks(3);
        check("cnt3", 32'(rt_if.bcd), 32'h0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
